shift_cmd_sequencer: RTL and testbench

Buffered command front end for the 32-bit barrel shifter datapath. Accepts shift commands (direction, amount, data) over a valid/ready handshake and queues them in a small FIFO. It presents the FIFO head to the combinational barrel shifter and registers the shifter's result into an output stage with its own valid/ready handshake. This gives the shifter a clean registered boundary on both sides and decouples producer and consumer back-pressure.

---
 rtl/shift_cmd_sequencer_if.sv | 42 ++++
 rtl/shift_cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_sequencer_if.sv
// Signal bundle between a command producer/result consumer and shift_cmd_sequencer.
// done_cnt is present only when SHIFT_SEQ_DONE_CNT_EN is defined.
interface shift_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic             in_dir;
  logic [4:0]       in_amt;
  logic [31:0]      in_data;
  logic             shf_dir;
  logic [4:0]       shf_amt;
  logic [31:0]      shf_din;
  logic [31:0]      shf_dout;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [LVL_W-1:0] fifo_level;
`ifdef SHIFT_SEQ_DONE_CNT_EN
  logic [15:0]      done_cnt;

  modport slave (
    input  in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
    output in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, fifo_level, done_cnt
  );
  modport master (
    output in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
    input  in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, fifo_level, done_cnt
  );
`else
  modport slave (
    input  in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
    output in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, fifo_level
  );
  modport master (
    output in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
    input  in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, fifo_level
  );
`endif
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO feeding a combinational barrel shifter, with a registered result stage.
// Optional SHIFT_SEQ_DONE_CNT_EN adds a 16-bit completed-result counter (done_cnt).
module shift_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_cmd_sequencer_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              dir;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} out_state_t;

  cmd_t              mem [DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_nxt;
  logic              in_ready_q;
  out_state_t        state_q;
  logic [DATA_W-1:0] out_data_q;
  logic              fifo_nonempty;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign fifo_nonempty = (level_q != '0);
  assign out_valid     = (state_q == S_FULL);
  assign push          = bus.in_valid && in_ready_q;
  assign pop           = fifo_nonempty && (!out_valid || bus.out_ready);

  // Next occupancy; push is already blocked when full, so level never exceeds DEPTH.
  always_comb begin
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level_q    <= level_nxt;
      in_ready_q <= (level_nxt < LVL_W'(DEPTH));
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_dir, bus.in_amt, bus.in_data};
    end
  end

  assign head = mem[rd_ptr];

  // Output stage: EMPTY/FULL with registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (pop) begin
            state_q    <= S_FULL;
            out_data_q <= bus.shf_dout;
          end
        end
        S_FULL: begin
          if (pop) begin
            out_data_q <= bus.shf_dout;
          end else if (bus.out_ready) begin
            state_q <= S_EMPTY;
          end
        end
      endcase
    end
  end

`ifdef SHIFT_SEQ_DONE_CNT_EN
  logic [15:0] done_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (out_valid && bus.out_ready) begin
      done_cnt_q <= done_cnt_q + 16'(1);
    end
  end

  assign bus.done_cnt = done_cnt_q;
`endif

  // Shifter is fed zeros whenever there is no head entry.
  assign bus.shf_dir    = fifo_nonempty ? head.dir  : 1'b0;
  assign bus.shf_amt    = fifo_nonempty ? head.amt  : '0;
  assign bus.shf_din    = fifo_nonempty ? head.data : '0;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed self-checking bench for shift_cmd_sequencer with a behavioural barrel shifter.
// Build with SHIFT_SEQ_DONE_CNT_EN defined to also exercise done_cnt.
module tb_shift_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  shift_cmd_sequencer_if #(.DEPTH(4)) bus ();

  shift_cmd_sequencer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational shifter: dir 1 = left, 0 = right
  assign bus.shf_dout = bus.shf_dir ? (bus.shf_din << bus.shf_amt) : (bus.shf_din >> bus.shf_amt);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic d, input logic [4:0] a, input logic [31:0] x);
    bus.in_valid = v;
    bus.in_dir   = d;
    bus.in_amt   = a;
    bus.in_data  = x;
  endtask

  task automatic do_reset();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if ({bus.shf_dir, bus.shf_amt, bus.shf_din} !== 38'd0) begin errors++; $display("FAIL reset_shf: got %b/%0d/%h want 0", bus.shf_dir, bus.shf_amt, bus.shf_din); end
`ifdef SHIFT_SEQ_DONE_CNT_EN
    checks++; if (bus.done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d want 0", bus.done_cnt); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL idle_after_reset: ready %b level %0d want 1/0", bus.in_ready, bus.fifo_level); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive_cmd(1'b1, 1'b1, 5'd4, 32'h0000_00FF);
    tick();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_k: got %0d want 1", bus.fifo_level); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", bus.out_valid); end
    checks++; if ({bus.shf_dir, bus.shf_amt, bus.shf_din} !== {1'b1, 5'd4, 32'h0000_00FF}) begin errors++; $display("FAIL single_shf_head: got %b/%0d/%h want 1/4/000000ff", bus.shf_dir, bus.shf_amt, bus.shf_din); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0000_0FF0) begin errors++; $display("FAIL single_data: got %h want 00000ff0", bus.out_data); end
    checks++; if (bus.shf_din !== 32'd0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL single_empty_shf: din %h level %0d want 0/0", bus.shf_din, bus.fifo_level); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0000_0FF0) begin errors++; $display("FAIL single_hold: got %h want 00000ff0", bus.out_data); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_s [8];
    exp_s = '{32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
              32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0100_0000};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(1'b1, 1'b0, 5'(i), 32'h8000_0000);
      tick();
      checks++; if (bus.fifo_level > 3'd1) begin errors++; $display("FAIL stream_level[%0d]: got %0d want <=1", i, bus.fifo_level); end
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_s[i-1]) begin errors++; $display("FAIL stream_data[%0d]: got %b/%h want 1/%h", i - 1, bus.out_valid, bus.out_data, exp_s[i-1]); end
      end
    end
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_s[7]) begin errors++; $display("FAIL stream_data[7]: got %b/%h want 1/%h", bus.out_valid, bus.out_data, exp_s[7]); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", bus.out_valid); end
`ifdef SHIFT_SEQ_DONE_CNT_EN
    checks++; if (bus.done_cnt !== 16'd8) begin errors++; $display("FAIL stream_done_cnt: got %0d want 8", bus.done_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_b [5];
    exp_b = '{32'd2, 32'd4, 32'd8, 32'd16, 32'd32};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cmd(1'b1, 1'b1, 5'(i + 1), 32'd1);
      tick();
    end
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", bus.fifo_level); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[0]) begin errors++; $display("FAIL bp_data[0]: got %b/%h want 1/%h", bus.out_valid, bus.out_data, exp_b[0]); end
    bus.out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[j]) begin errors++; $display("FAIL bp_data[%0d]: got %b/%h want 1/%h", j, bus.out_valid, bus.out_data, exp_b[j]); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL bp_drain: valid %b level %0d want 0/0", bus.out_valid, bus.fifo_level); end
  endtask

  task automatic test_full_pop();
    logic [31:0] fill [5];
    logic [31:0] exp_f [4];
    fill  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    exp_f = '{32'h33, 32'h44, 32'h55, 32'h66};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, 1'b0, 5'd0, fill[i]);
      tick();
    end
    drive_cmd(1'b1, 1'b0, 5'd0, 32'h66);
    checks++; if (bus.in_ready !== 1'b0 || bus.fifo_level !== 3'd4) begin errors++; $display("FAIL full_state: ready %b level %0d want 0/4", bus.in_ready, bus.fifo_level); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d want 3", bus.fifo_level); end
    checks++; if (bus.out_data !== 32'h22) begin errors++; $display("FAIL full_pop_data: got %h want 00000022", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b0;
    tick();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.fifo_level !== 3'd4 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_repush: level %0d ready %b want 4/0", bus.fifo_level, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_f[j]) begin errors++; $display("FAIL full_order[%0d]: got %b/%h want 1/%h", j, bus.out_valid, bus.out_data, exp_f[j]); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL full_drain: valid %b level %0d want 0/0", bus.out_valid, bus.fifo_level); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 1'b1, 5'd1, 32'(i + 1));
      tick();
    end
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.fifo_level !== 3'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: level %0d valid %b want 3/1", bus.fifo_level, bus.out_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) begin errors++; $display("FAIL mid_out: valid %b data %h want 0/0", bus.out_valid, bus.out_data); end
    checks++; if (bus.fifo_level !== 3'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo: level %0d ready %b want 0/1", bus.fifo_level, bus.in_ready); end
    checks++; if ({bus.shf_dir, bus.shf_amt, bus.shf_din} !== 38'd0) begin errors++; $display("FAIL mid_shf: got %b/%0d/%h want 0", bus.shf_dir, bus.shf_amt, bus.shf_din); end
`ifdef SHIFT_SEQ_DONE_CNT_EN
    checks++; if (bus.done_cnt !== 16'd0) begin errors++; $display("FAIL mid_done_cnt: got %0d want 0", bus.done_cnt); end
`endif
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive_cmd(1'b1, 1'b1, 5'd31, 32'h0000_0001);
    tick();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd1) begin errors++; $display("FAIL mid_accept: valid %b level %0d want 0/1", bus.out_valid, bus.fifo_level); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8000_0000) begin errors++; $display("FAIL mid_left31: got %b/%h want 1/80000000", bus.out_valid, bus.out_data); end
    tick();
  endtask

  task automatic test_boundaries();
    bus.out_ready = 1'b1;
    drive_cmd(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    drive_cmd(1'b1, 1'b0, 5'd31, 32'h8000_0000);
    tick();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bnd_amt0: got %b/%h want 1/deadbeef", bus.out_valid, bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0001) begin errors++; $display("FAIL bnd_right31: got %b/%h want 1/00000001", bus.out_valid, bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bnd_drain: got %b want 0", bus.out_valid); end
  endtask

`ifdef SHIFT_SEQ_DONE_CNT_EN
  task automatic test_done_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    drive_cmd(1'b1, 1'b0, 5'd0, 32'd0);
    repeat (65536) tick();
    drive_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (bus.done_cnt !== 16'hFFFE) begin errors++; $display("FAIL wrap_fffe: got %h want fffe", bus.done_cnt); end
    tick();
    checks++; if (bus.done_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h want ffff", bus.done_cnt); end
    tick();
    checks++; if (bus.done_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bus.done_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_boundaries();
`ifdef SHIFT_SEQ_DONE_CNT_EN
    test_done_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
